// File: rtl/ahb_arb_pkg.sv
// Shared AHB arbiter definitions: transfer/response encodings, grant FSM state
// and the debug view exported by the grant controller.
package ahb_arb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;
    localparam logic [1:0] HRESP_RETRY = 2'b10;
    localparam logic [1:0] HRESP_SPLIT = 2'b11;

    typedef enum logic {
        OWN      = 1'b0,
        HANDOVER = 1'b1
    } grant_state_t;

    typedef struct packed {
        grant_state_t state;
        logic         arb_ok;
        logic         any_req;
    } grant_dbg_t;

endpackage

// File: rtl/ahb_grant_ctrl_if.sv
// Arbitration-side signal bundle between AHB masters, the finish detector
// and the grant controller.
interface ahb_grant_ctrl_if #(
    parameter int NUM_MASTERS = 4
);
    localparam int MW = $clog2(NUM_MASTERS);

    // hready is the only flow control: a pending handover completes on the
    // first rising edge with hready high. hbusreq/hlock are levels sampled
    // every edge; hgrant is their only acknowledge, with no ready/valid pairing.
    logic [NUM_MASTERS-1:0] hbusreq;
    logic [NUM_MASTERS-1:0] hlock;
    logic [1:0]             htrans;
    logic                   hready;
    logic                   transfin;
    logic [NUM_MASTERS-1:0] hgrant;
    logic [MW-1:0]          hmaster;
    logic                   hmastlock;

    modport master (
        output hbusreq, hlock, htrans, hready, transfin,
        input  hgrant, hmaster, hmastlock
    );

    modport slave (
        input  hbusreq, hlock, htrans, hready, transfin,
        output hgrant, hmaster, hmastlock
    );

endinterface

// File: rtl/ahb_rr_pick.sv
// Round-robin pick: first requester after grant_idx (wrapping, ending at
// grant_idx itself); parks on DEFAULT_MASTER when nobody requests.
module ahb_rr_pick #(
    parameter  int NUM_MASTERS    = 4,
    parameter  int DEFAULT_MASTER = 0,
    localparam int MW             = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] hbusreq,
    input  logic [MW-1:0]          grant_idx,
    output logic [MW-1:0]          winner,
    output logic                   any_req
);

    // One spare bit so grant_idx + offset never overflows before the wrap.
    logic [MW:0] probe;
    logic        found;

    always_comb begin
        winner = MW'(DEFAULT_MASTER);
        found  = 1'b0;
        probe  = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            probe = {1'b0, grant_idx} + (MW+1)'(i);
            if (probe >= (MW+1)'(NUM_MASTERS)) begin
                probe = probe - (MW+1)'(NUM_MASTERS);
            end
            if (!found && hbusreq[probe[MW-1:0]]) begin
                winner = probe[MW-1:0];
                found  = 1'b1;
            end
        end
    end

    assign any_req = |hbusreq;

endmodule

// File: rtl/ahb_grant_ctrl.sv
// AHB grant controller: round-robin hgrant, then hmaster/hmastlock handed
// over one address phase later on the first hready edge.
module ahb_grant_ctrl
    import ahb_arb_pkg::*;
#(
    parameter  int NUM_MASTERS    = 4,
    parameter  int DEFAULT_MASTER = 0,
    localparam int MW             = $clog2(NUM_MASTERS)
) (
    input  logic             hclk,
    input  logic             hreset,
    ahb_grant_ctrl_if.slave  bus,
    output grant_dbg_t       dbg
);

    localparam logic [MW-1:0]          DEF_IDX   = MW'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;

    grant_state_t           state_q,     state_nxt;
    logic [MW-1:0]          grant_idx_q, grant_idx_nxt;
    logic                   lock_q,      lock_nxt;
    logic [NUM_MASTERS-1:0] hgrant_q,    hgrant_nxt;
    logic [MW-1:0]          hmaster_q,   hmaster_nxt;
    logic                   hmastlock_q, hmastlock_nxt;

    logic [MW-1:0] winner;
    logic          any_req;
    logic          addr_active;
    logic          arb_ok;

    ahb_rr_pick #(
        .NUM_MASTERS    (NUM_MASTERS),
        .DEFAULT_MASTER (DEFAULT_MASTER)
    ) u_pick (
        .hbusreq   (bus.hbusreq),
        .grant_idx (grant_idx_q),
        .winner    (winner),
        .any_req   (any_req)
    );

    assign addr_active = (bus.htrans == HTRANS_NONSEQ) || (bus.htrans == HTRANS_SEQ);
    // A locked owner blocks rearbitration until it drops hlock itself.
    assign arb_ok = (state_q == OWN) && bus.hready && (bus.transfin || !addr_active)
                    && !bus.hlock[grant_idx_q];

    always_comb begin
        state_nxt     = state_q;
        grant_idx_nxt = grant_idx_q;
        lock_nxt      = lock_q;
        hgrant_nxt    = hgrant_q;
        hmaster_nxt   = hmaster_q;
        hmastlock_nxt = hmastlock_q;
        case (state_q)
            OWN: begin
                if (bus.hready && (hmaster_q == grant_idx_q)) begin
                    hmastlock_nxt = bus.hlock[hmaster_q];
                end
                if (arb_ok) begin
                    lock_nxt = bus.hlock[winner];
                    if (winner != grant_idx_q) begin
                        grant_idx_nxt      = winner;
                        hgrant_nxt         = '0;
                        hgrant_nxt[winner] = 1'b1;
                        state_nxt          = HANDOVER;
                    end
                end
            end
            HANDOVER: begin
                if (bus.hready) begin
                    hmaster_nxt   = grant_idx_q;
                    hmastlock_nxt = lock_q;
                    state_nxt     = OWN;
                end
            end
            default: state_nxt = OWN;
        endcase
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q     <= OWN;
            grant_idx_q <= DEF_IDX;
            lock_q      <= 1'b0;
            hgrant_q    <= DEF_GRANT;
            hmaster_q   <= DEF_IDX;
            hmastlock_q <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            grant_idx_q <= grant_idx_nxt;
            lock_q      <= lock_nxt;
            hgrant_q    <= hgrant_nxt;
            hmaster_q   <= hmaster_nxt;
            hmastlock_q <= hmastlock_nxt;
        end
    end

    assign bus.hgrant    = hgrant_q;
    assign bus.hmaster   = hmaster_q;
    assign bus.hmastlock = hmastlock_q;

    always_comb begin
        dbg         = '0;
        dbg.state   = state_q;
        dbg.arb_ok  = arb_ok;
        dbg.any_req = any_req;
    end

endmodule

// File: tb/tb_ahb_grant_ctrl.sv
// Self-checking bench for ahb_grant_ctrl: cycle model feeding an expected
// queue, directed scenarios, then randomized traffic with sporadic resets.
module tb_ahb_grant_ctrl;
    import ahb_arb_pkg::*;

    localparam int N   = 4;
    localparam int MW  = 2;
    localparam int DEF = 0;
    localparam int W   = 1 + N + MW + 1;

    logic       hclk;
    logic       hreset;
    grant_dbg_t dbg;

    ahb_grant_ctrl_if #(.NUM_MASTERS(N)) bus();

    ahb_grant_ctrl #(
        .NUM_MASTERS    (N),
        .DEFAULT_MASTER (DEF)
    ) dut (
        .hclk   (hclk),
        .hreset (hreset),
        .bus    (bus),
        .dbg    (dbg)
    );

    // ---------------- clock ----------------
    initial begin
        hclk = 1'b0;
        forever #5 hclk = ~hclk;
    end

    // ---------------- scoreboard state ----------------
    int             n_checks;
    int             n_pass;
    logic [W-1:0]   exp_q[$];
    int             grant_order[$];
    logic           recording;
    logic [N-1:0]   prev_grant;

    // reference model registers
    int m_state, m_gidx, m_lock, m_grant, m_hmaster, m_hmastlock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int onehot_idx(input logic [N-1:0] g);
        for (int i = 0; i < N; i++) if (g[i]) return i;
        return -1;
    endfunction

    task automatic model_step(input logic rst, input logic [N-1:0] req, input logic [N-1:0] lk,
                              input logic [1:0] tr, input logic rdy, input logic tf);
        int ok, w, found, j;
        int n_state, n_gidx, n_lock, n_grant, n_hmaster, n_hmastlock;
        if (rst) begin
            m_state = 0; m_gidx = DEF; m_lock = 0;
            m_grant = 1 << DEF; m_hmaster = DEF; m_hmastlock = 0;
            return;
        end
        ok = (m_state == 0 && rdy && (tf || !tr[1]) && !lk[m_gidx]) ? 1 : 0;
        w = DEF;
        found = 0;
        for (int k = 1; k <= N; k++) begin
            j = (m_gidx + k) % N;
            if (found == 0 && req[j]) begin
                w = j;
                found = 1;
            end
        end
        n_state = m_state; n_gidx = m_gidx; n_lock = m_lock;
        n_grant = m_grant; n_hmaster = m_hmaster; n_hmastlock = m_hmastlock;
        if (m_state == 0) begin
            if (rdy && m_hmaster == m_gidx) n_hmastlock = lk[m_hmaster] ? 1 : 0;
            if (ok != 0) begin
                n_lock = lk[w] ? 1 : 0;
                if (w != m_gidx) begin
                    n_gidx  = w;
                    n_grant = 1 << w;
                    n_state = 1;
                end
            end
        end else if (rdy) begin
            n_hmaster   = m_gidx;
            n_hmastlock = m_lock;
            n_state     = 0;
        end
        m_state = n_state; m_gidx = n_gidx; m_lock = n_lock;
        m_grant = n_grant; m_hmaster = n_hmaster; m_hmastlock = n_hmastlock;
    endtask

    function automatic logic [W-1:0] model_pack();
        logic [W-1:0] p;
        p = {m_state[0], m_grant[N-1:0], m_hmaster[MW-1:0], m_hmastlock[0]};
        return p;
    endfunction

    task automatic sb_compare();
        logic [W-1:0] e;
        check("sb_depth", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        check("state",     32'(dbg.state),              32'(e[W-1]));
        check("hgrant",    32'(bus.hgrant),             32'(e[W-2 -: N]));
        check("hmaster",   32'(bus.hmaster),            32'(e[MW:1]));
        check("hmastlock", 32'(bus.hmastlock),          32'(e[0]));
        check("onehot",    32'($countones(bus.hgrant)), 32'd1);
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic rst, input logic [N-1:0] req, input logic [N-1:0] lk,
                         input logic [1:0] tr, input logic rdy, input logic tf);
        hreset       = rst;
        bus.hbusreq  = req;
        bus.hlock    = lk;
        bus.htrans   = tr;
        bus.hready   = rdy;
        bus.transfin = tf;
        model_step(rst, req, lk, tr, rdy, tf);
        exp_q.push_back(model_pack());
        @(posedge hclk);
        #1;
        sb_compare();
        if (recording && bus.hgrant !== prev_grant) grant_order.push_back(onehot_idx(bus.hgrant));
        prev_grant = bus.hgrant;
    endtask

    // ---------------- stimulus ----------------
    int rr_exp[5];

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        recording  = 1'b0;
        prev_grant = '0;
        rr_exp     = '{1, 2, 3, 0, 1};

        // Reset with random inputs, then quiet bus
        repeat (2) drive(1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                         2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        check("rst_hgrant",    32'(bus.hgrant),    32'h1);
        check("rst_hmaster",   32'(bus.hmaster),   32'h0);
        check("rst_hmastlock", 32'(bus.hmastlock), 32'h0);
        repeat (3) drive(1'b0, 4'b0000, 4'b0000, HTRANS_IDLE, 1'b1, 1'b0);
        check("idle_hgrant",  32'(bus.hgrant),  32'h1);
        check("idle_hmaster", 32'(bus.hmaster), 32'h0);

        // Round-robin with all masters requesting
        recording  = 1'b1;
        prev_grant = bus.hgrant;
        for (int c = 0; c < 20; c++) drive(1'b0, 4'b1111, 4'b0000, HTRANS_NONSEQ, 1'b1, (c % 4) == 0);
        recording = 1'b0;
        check("rr_count", 32'(grant_order.size()), 32'd5);
        for (int i = 0; i < grant_order.size() && i < 5; i++) check("rr_order", 32'(grant_order[i]), 32'(rr_exp[i]));

        // Handover stall: 0 -> 2 with hready low for 3 cycles
        drive(1'b1, 4'b0000, 4'b0000, HTRANS_IDLE, 1'b1, 1'b0);
        drive(1'b0, 4'b0100, 4'b0000, HTRANS_IDLE, 1'b1, 1'b0);
        check("stall_hgrant",  32'(bus.hgrant),  32'h4);
        check("stall_hm_pre",  32'(bus.hmaster), 32'h0);
        repeat (3) begin
            drive(1'b0, 4'b0100, 4'b0000, HTRANS_IDLE, 1'b0, 1'b0);
            check("stall_hm_hold", 32'(bus.hmaster), 32'h0);
        end
        drive(1'b0, 4'b0100, 4'b0000, HTRANS_IDLE, 1'b1, 1'b0);
        check("stall_hmaster", 32'(bus.hmaster), 32'h2);

        // Lock hold: master 1 locked, then releases
        drive(1'b0, 4'b0010, 4'b0010, HTRANS_IDLE, 1'b1, 1'b0);
        check("lock_hgrant1", 32'(bus.hgrant), 32'h2);
        drive(1'b0, 4'b0010, 4'b0010, HTRANS_NONSEQ, 1'b1, 1'b0);
        check("lock_hmastlock", 32'(bus.hmastlock), 32'h1);
        repeat (4) begin
            drive(1'b0, 4'b1010, 4'b0010, HTRANS_SEQ, 1'b1, 1'b1);
            check("lock_hold", 32'(bus.hgrant), 32'h2);
        end
        drive(1'b0, 4'b1010, 4'b0000, HTRANS_SEQ, 1'b1, 1'b1);
        check("lock_release", 32'(bus.hgrant), 32'h8);
        drive(1'b0, 4'b1000, 4'b0000, HTRANS_NONSEQ, 1'b1, 1'b0);
        check("lock_hmaster3", 32'(bus.hmaster), 32'h3);

        // Park on default master when idle
        drive(1'b0, 4'b0000, 4'b0000, HTRANS_IDLE, 1'b1, 1'b0);
        check("park_hgrant", 32'(bus.hgrant), 32'h1);
        drive(1'b0, 4'b0000, 4'b0000, HTRANS_IDLE, 1'b1, 1'b0);
        check("park_hmaster",   32'(bus.hmaster),   32'h0);
        check("park_hmastlock", 32'(bus.hmastlock), 32'h0);

        // Reset while a handover is pending
        drive(1'b0, 4'b0100, 4'b0000, HTRANS_IDLE, 1'b1, 1'b0);
        check("ho_state", 32'(dbg.state), 32'(HANDOVER));
        drive(1'b1, 4'b0100, 4'b0000, HTRANS_IDLE, 1'b0, 1'b0);
        check("ho_rst_state",   32'(dbg.state),   32'(OWN));
        check("ho_rst_hgrant",  32'(bus.hgrant),  32'h1);
        check("ho_rst_hmaster", 32'(bus.hmaster), 32'h0);

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            drive(1'($urandom_range(0, 49) == 0),
                  4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15)),
                  2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 2) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ahb_grant_ctrl.md
# ahb_grant_ctrl

Grant controller for the AHB arbiter, directly downstream of the transfer-finish detector. It consumes `transfin` together with master requests and lock lines, runs round-robin arbitration, and drives the one-hot `hgrant`. It also drives `hmaster` and `hmastlock` with the AHB address-phase handover timing. When no master is requesting, the bus parks on a default master.

## Interface

Parameters:
- `NUM_MASTERS`, 4: number of masters, legal range 2..16.
- `DEFAULT_MASTER`, 0: park master index, must be < `NUM_MASTERS`.
- `MW`, `$clog2(NUM_MASTERS)`: width of `hmaster`; derived, not overridden.

Ports (one clock `hclk`; reset `hreset` is synchronous and active-high):
- `hclk` in 1: bus clock; all state updates on its rising edge.
- `hreset` in 1: synchronous, active-high reset.
- `hbusreq` in `NUM_MASTERS`: per-master bus request.
- `hlock` in `NUM_MASTERS`: per-master locked-transfer request.
- `htrans` in 2: current address-phase transfer type; bit 1 high means NONSEQ or SEQ.
- `hready` in 1: slave ready.
- `transfin` in 1: the current burst or locked sequence has reached its last transfer (from the transfer-finish detector).
- `hgrant` out `NUM_MASTERS`: one-hot grant, registered.
- `hmaster` out `MW`: index of the master owning the address phase, registered.
- `hmastlock` out 1: current address-phase owner is performing a locked sequence, registered.

## Operation

- Internal state: `state` ∈ {OWN, HANDOVER}, `grant_idx` (`MW` bits), `lock_q` (1 bit).
- Reset values: state=OWN, `grant_idx`=`DEFAULT_MASTER`, `hgrant`=one-hot(`DEFAULT_MASTER`), `hmaster`=`DEFAULT_MASTER`, `hmastlock`=0, `lock_q`=0.
- Rearbitration is allowed when `arb_ok` = (state==OWN) & `hready` & (`transfin` | `htrans[1]`==0) & ~`hlock[grant_idx]`.
- Winner selection (combinational):
  - Search `hbusreq` starting at `grant_idx`+1, wrapping modulo `NUM_MASTERS`, ending at `grant_idx` itself.
  - The first requester found wins.
  - If there are no requests, the winner is `DEFAULT_MASTER`.
- OWN, with `arb_ok` and winner ≠ `grant_idx`:
  - Load `grant_idx`←winner and `hgrant`←one-hot(winner).
  - Load `lock_q`←`hlock[winner]`.
  - Go to HANDOVER.
- OWN, with `arb_ok` and winner == `grant_idx`:
  - Refresh `lock_q`←`hlock[winner]`.
  - Stay in OWN; `hgrant` is unchanged.
- OWN, without `arb_ok`: hold all state. A locked owner keeps the bus until it deasserts `hlock` and `transfin` or an idle cycle occurs.
- HANDOVER, with `hready`=1:
  - Load `hmaster`←`grant_idx` and `hmastlock`←`lock_q`.
  - Go to OWN.
- HANDOVER, with `hready`=0: hold. Requests and `transfin` are ignored; no rearbitration is possible while a handover is pending.
- OWN, when `hmaster`==`grant_idx` and `hready`=1: `hmastlock`←`hlock[hmaster]` every cycle, so lock drops track the owner.
- `hreset` asserted in any state, including HANDOVER: all registers return to their reset values on the next edge. Reset has priority over all other updates.

## Timing

- Grant latency: `arb_ok` in cycle t updates `hgrant` at edge t+1.
- `hmaster` and `hmastlock` update at the first edge after t+1 at which `hready`=1. Minimum latency is 2 edges from the arbitration cycle.
- `hgrant` is never zero and never multi-hot, including during reset.
- Simultaneous `transfin` and an idle `htrans` count as one `arb_ok`.
- A request deasserted in the same cycle as `arb_ok` is not seen; the inputs sampled that cycle decide.

## Structure

- Shared package `ahb_arb_pkg`: HTRANS encodings (IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11), HRESP encodings (OKAY, ERROR, RETRY, SPLIT), and the state encoding (OWN=1'b0, HANDOVER=1'b1).
- Sub-module `ahb_rr_pick`: purely combinational rotate-and-priority-encode.
  - Inputs: `hbusreq`, `grant_idx`.
  - Outputs: `winner`, `any_req`.
  - Parameterised by `NUM_MASTERS` and `DEFAULT_MASTER`.
- Estimated size: top level ~150 lines, `ahb_rr_pick` ~60 lines.

## Test plan

- Reset: hold `hreset`=1 for 2 cycles with random inputs → `hgrant`=4'b0001, `hmaster`=0, `hmastlock`=0; after release with no requests, outputs stay unchanged.
- Round-robin: `hbusreq`=4'b1111, `transfin` pulsed every 4 cycles, `hready`=1 → grant order 1,2,3,0,1; each `hmaster` change lags its `hgrant` change by exactly 1 edge.
- Handover stall: grant moves 0→2 while `hready`=0 for 3 cycles → `hgrant`=4'b0100 immediately, `hmaster` stays 0 until the first `hready`=1 edge, then becomes 2.
- Lock hold: master 1 owns with `hlock[1]`=1, `transfin`=1, and `hbusreq`=4'b1010 → no grant change; once `hlock[1]`=0 and `transfin`=1 → `hgrant`=4'b1000.
- Park and idle: all requests drop and `htrans`=IDLE with owner 3 → `hgrant`=4'b0001, then `hmaster`=0 and `hmastlock`=0.
- Reset mid-HANDOVER: assert `hreset` with state=HANDOVER and `hready`=0 → next edge shows reset values and state=OWN.
